llsc_ctrl: RTL and testbench
============================

// Module: llsc_ctrl
// PURPOSE
//  MEM-stage LL/SC control: the writer side of the LLbit register. Decides SC success,
//  gates the SC store, tracks the linked address, snoops foreign writes, and issues the
//  LLbit write (value + we) to the LLbit register. Sits between MEM and the data bus.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width (SC result width)
//  GRAN_LSB 2   log2 link granule in bytes; compare addr[ADDR_W-1:GRAN_LSB]
// PORTS
//  clk            in   1       clock
//  rst            in   1       sync reset, active-high
//  flush          in   1       pipeline flush (exception/eret)
//  is_ll          in   1       MEM holds LL
//  is_sc          in   1       MEM holds SC
//  mem_addr       in   ADDR_W  effective address of LL/SC
//  LLbit_i        in   1       current LLbit register value
//  wb_LLbit_we    in   1       LLbit write pending in MEM/WB (bypass)
//  wb_LLbit_val   in   1       value of that pending write
//  snoop_we       in   1       foreign master write strobe
//  snoop_addr     in   ADDR_W  foreign write address
//  mem_ack        in   1       data-bus access done
//  mem_we_o       out  1       store enable to bus (SC store only if success)
//  sc_result_o    out  DATA_W  rt value for SC: 1 success, 0 fail
//  stallreq_o     out  1       stall pipeline while awaiting mem_ack
//  LLbit_o        out  1       value to LLbit register
//  LLbit_we_o     out  1       write enable to LLbit register (1-cycle pulse)
// BEHAVIOUR
//  - Reset: state IDLE, link_valid=0, link_addr=0; all outputs 0.
//  - Effective LLbit eff = wb_LLbit_we ? wb_LLbit_val : LLbit_i (combinational bypass).
//  - States: IDLE, LL_WAIT, SC_WAIT.
//  - IDLE+is_ll: -> LL_WAIT, stallreq_o=1 combinationally until ack cycle.
//  - LL_WAIT+mem_ack: latch link_addr, link_valid=1; next cycle LLbit_o=1, LLbit_we_o=1; -> IDLE.
//  - IDLE+is_sc: ok = eff & match (see CONFIGURATION). ok=1: mem_we_o=1, stallreq_o=1,
//    -> SC_WAIT. ok=0: no store, sc_result_o=0 same cycle, no stall, stay IDLE, no LLbit write.
//  - SC_WAIT: mem_we_o held 1 until mem_ack; on ack sc_result_o=1, stallreq_o=0, link_valid=0;
//    next cycle LLbit_o=0, LLbit_we_o=1; -> IDLE.
//  - sc_result_o valid only in the cycle SC completes; else 0. Zero-extended to DATA_W.
//  - Snoop (snoop_we & snoop_addr granule == link_addr granule & link_valid): link_valid=0;
//    next cycle LLbit_o=0, LLbit_we_o=1. In SC_WAIT the in-flight store still completes as success.
//    Same-cycle snoop and LL ack: LL wins (link set, LLbit=1).
//  - mem_ack with no pending access: ignored.
//  - flush: any state -> IDLE, link_valid=0, mem_we_o/stallreq_o/LLbit_we_o=0 that cycle;
//    no LLbit write issued (LLbit register clears itself on flush). Pending LLbit pulse dropped.
//  - rst overrides flush; mid-operation rst aborts to reset state, no pulse.
//  - Back-to-back: new LL/SC accepted in the IDLE cycle after completion; LLbit pulse for the
//    prior op and the new op's bypass use wb_LLbit_* so SC right after LL sees eff=1.
// CONFIGURATION
//  LLSC_ADDR_CHECK_EN defined: match = link_valid & (mem_addr granule == link_addr granule);
//    snoop clearing active.
//  Not defined: match = 1 (SC depends on eff only); link_addr/snoop logic absent, snoop ignored.
// TESTING
//  1 LL @0x100, ack after 2 cycles -> stall 3 cycles, then LLbit_we_o=1,LLbit_o=1 one cycle.
//  2 LL @0x100 then SC @0x100, eff=1 -> mem_we_o=1 until ack, sc_result_o=1, LLbit 0 written.
//  3 SC with LLbit_i=0, no bypass -> mem_we_o=0, sc_result_o=0, no stall, LLbit_we_o=0.
//  4 LL @0x100, snoop write 0x102 -> LLbit_o=0 pulse; SC @0x100 fails (ADDR_CHECK_EN).
//    Without macro: snoop ignored, LLbit untouched.
//  5 SC @0x104 after LL @0x100 (macro on) -> fail, sc_result_o=0; macro off -> success.
//  6 flush in SC_WAIT -> next cycle IDLE, mem_we_o=0, stallreq_o=0, no LLbit_we_o pulse.

Source files
------------

// File: rtl/llsc_ctrl.sv
// llsc_ctrl: MEM-stage LL/SC controller that decides SC success and drives LLbit register writes.
// Define LLSC_ADDR_CHECK_EN to enable linked-address matching and foreign-write snoop clearing.
module llsc_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int GRAN_LSB = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              is_ll,
    input  logic              is_sc,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              LLbit_i,
    input  logic              wb_LLbit_we,
    input  logic              wb_LLbit_val,
    input  logic              snoop_we,
    input  logic [ADDR_W-1:0] snoop_addr,
    input  logic              mem_ack,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] sc_result_o,
    output logic              stallreq_o,
    output logic              LLbit_o,
    output logic              LLbit_we_o
);

    typedef enum logic [1:0] {IDLE, LL_WAIT, SC_WAIT} state_t;

    state_t state, state_nxt;
    logic   eff_llbit;
    logic   addr_match;
    logic   sc_ok;
    logic   ll_done;
    logic   sc_done;
    logic   snoop_hit;
    logic   pulse_q;
    logic   pulse_val_q;

    // An LLbit write still sitting in MEM/WB takes precedence over the register value.
    assign eff_llbit = wb_LLbit_we ? wb_LLbit_val : LLbit_i;
    assign sc_ok     = eff_llbit & addr_match;
    assign ll_done   = (state == LL_WAIT) && mem_ack && !flush;
    assign sc_done   = (state == SC_WAIT) && mem_ack && !flush;

`ifdef LLSC_ADDR_CHECK_EN
    logic              link_valid;
    logic [ADDR_W-1:0] link_addr;

    assign addr_match = link_valid &&
                        (mem_addr[ADDR_W-1:GRAN_LSB] == link_addr[ADDR_W-1:GRAN_LSB]);
    assign snoop_hit  = snoop_we && link_valid &&
                        (snoop_addr[ADDR_W-1:GRAN_LSB] == link_addr[ADDR_W-1:GRAN_LSB]);

    // A completing LL re-arms the link even if a snoop hits the old link in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else if (flush) begin
            link_valid <= 1'b0;
        end else if (ll_done) begin
            link_valid <= 1'b1;
            link_addr  <= mem_addr;
        end else if (sc_done || snoop_hit) begin
            link_valid <= 1'b0;
        end
    end
`else
    logic unused_link_inputs;

    assign addr_match         = 1'b1;
    assign snoop_hit          = 1'b0;
    assign unused_link_inputs = ^{snoop_we, snoop_addr, mem_addr};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (is_ll) begin
                        state_nxt = LL_WAIT;
                    end else if (is_sc && sc_ok) begin
                        state_nxt = SC_WAIT;
                    end
                end
                LL_WAIT, SC_WAIT: begin
                    if (mem_ack) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // LLbit writes are issued one cycle after the event; a flush drops them.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q     <= 1'b0;
            pulse_val_q <= 1'b0;
        end else begin
            pulse_q     <= !flush && (ll_done || sc_done || snoop_hit);
            pulse_val_q <= ll_done;
        end
    end

    always_comb begin
        mem_we_o    = 1'b0;
        sc_result_o = '0;
        stallreq_o  = 1'b0;
        LLbit_o     = 1'b0;
        LLbit_we_o  = 1'b0;
        if (!rst && !flush) begin
            LLbit_we_o = pulse_q;
            LLbit_o    = pulse_q & pulse_val_q;
            unique case (state)
                IDLE: begin
                    if (is_ll) begin
                        stallreq_o = 1'b1;
                    end else if (is_sc && sc_ok) begin
                        mem_we_o   = 1'b1;
                        stallreq_o = 1'b1;
                    end
                end
                LL_WAIT: begin
                    stallreq_o = !mem_ack;
                end
                SC_WAIT: begin
                    mem_we_o       = 1'b1;
                    stallreq_o     = !mem_ack;
                    sc_result_o[0] = mem_ack;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_llsc_ctrl.sv
// tb_llsc_ctrl: directed and randomized LL/SC traffic checked by a scoreboard against a
// transaction-level model; follows LLSC_ADDR_CHECK_EN the same way the design does.
module tb_llsc_ctrl;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int GRAN_LSB = 2;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              is_ll;
    logic              is_sc;
    logic [ADDR_W-1:0] mem_addr;
    logic              LLbit_i;
    logic              wb_LLbit_we;
    logic              wb_LLbit_val;
    logic              snoop_we;
    logic [ADDR_W-1:0] snoop_addr;
    logic              mem_ack;
    logic              mem_we_o;
    logic [DATA_W-1:0] sc_result_o;
    logic              stallreq_o;
    logic              LLbit_o;
    logic              LLbit_we_o;

    typedef struct {
        logic              rst;
        logic              flush;
        logic              is_ll;
        logic              is_sc;
        logic [ADDR_W-1:0] addr;
        logic              llbit_i;
        logic              wb_we;
        logic              wb_val;
        logic              sn_we;
        logic [ADDR_W-1:0] sn_addr;
        logic              ack;
    } stim_t;

    typedef struct {
        logic              mem_we;
        logic              stall;
        logic [DATA_W-1:0] sc_res;
    } exp_t;

    typedef struct {
        int   cyc;
        logic val;
    } pulse_t;

    exp_t   exp_q[$];
    pulse_t pulse_q[$];
    int     checks = 0;
    int     passes = 0;
    int     cyc = 0;

    // Model: which access is outstanding, the current link, and the LLbit write owed next cycle.
    bit              m_busy_ll = 0;
    bit              m_busy_sc = 0;
    bit              m_link_v = 0;
    logic [ADDR_W-1:0] m_link_addr = '0;
    bit              m_pend = 0;
    bit              m_pend_val = 0;

    llsc_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .GRAN_LSB(GRAN_LSB)) dut (
        .clk(clk), .rst(rst), .flush(flush), .is_ll(is_ll), .is_sc(is_sc),
        .mem_addr(mem_addr), .LLbit_i(LLbit_i), .wb_LLbit_we(wb_LLbit_we),
        .wb_LLbit_val(wb_LLbit_val), .snoop_we(snoop_we), .snoop_addr(snoop_addr),
        .mem_ack(mem_ack), .mem_we_o(mem_we_o), .sc_result_o(sc_result_o),
        .stallreq_o(stallreq_o), .LLbit_o(LLbit_o), .LLbit_we_o(LLbit_we_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit same_gran(logic [ADDR_W-1:0] a, logic [ADDR_W-1:0] b);
        return (a >> GRAN_LSB) == (b >> GRAN_LSB);
    endfunction

    function automatic stim_t idle_s();
        stim_t s;
        s.rst = 0; s.flush = 0; s.is_ll = 0; s.is_sc = 0; s.addr = '0;
        s.llbit_i = 0; s.wb_we = 0; s.wb_val = 0; s.sn_we = 0; s.sn_addr = '0; s.ack = 0;
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end else begin
            passes++;
        end
    endtask

    // Drives one cycle of inputs and records what the design owes for that cycle.
    task automatic applyStimulus(input stim_t s);
        exp_t   e;
        pulse_t p;
        bit     eff, ok, old_link_v, new_pend, new_val;
        rst = s.rst; flush = s.flush; is_ll = s.is_ll; is_sc = s.is_sc; mem_addr = s.addr;
        LLbit_i = s.llbit_i; wb_LLbit_we = s.wb_we; wb_LLbit_val = s.wb_val;
        snoop_we = s.sn_we; snoop_addr = s.sn_addr; mem_ack = s.ack;
        cyc++;
        e.mem_we = 0; e.stall = 0; e.sc_res = '0;
        new_pend = 0; new_val = 0;
        if (m_pend && !s.rst && !s.flush) begin
            p.cyc = cyc; p.val = m_pend_val;
            pulse_q.push_back(p);
        end
        if (s.rst || s.flush) begin
            m_busy_ll = 0; m_busy_sc = 0; m_link_v = 0;
            if (s.rst) m_link_addr = '0;
        end else begin
            eff = s.wb_we ? s.wb_val : s.llbit_i;
            old_link_v = m_link_v;
            if (m_busy_ll) begin
                e.stall = !s.ack;
                if (s.ack) begin
                    m_busy_ll = 0; m_link_v = 1; m_link_addr = s.addr;
                    new_pend = 1; new_val = 1;
                end
            end else if (m_busy_sc) begin
                e.mem_we = 1;
                e.stall = !s.ack;
                if (s.ack) begin
                    e.sc_res = 1;
                    m_busy_sc = 0; m_link_v = 0;
                    new_pend = 1; new_val = 0;
                end
            end else if (s.is_ll) begin
                e.stall = 1;
                m_busy_ll = 1;
            end else if (s.is_sc) begin
`ifdef LLSC_ADDR_CHECK_EN
                ok = eff && old_link_v && same_gran(s.addr, m_link_addr);
`else
                ok = eff;
`endif
                if (ok) begin
                    e.mem_we = 1; e.stall = 1; m_busy_sc = 1;
                end
            end
`ifdef LLSC_ADDR_CHECK_EN
            if (s.sn_we && old_link_v && !(new_pend && new_val) && same_gran(s.sn_addr, m_link_addr)) begin
                m_link_v = 0; new_pend = 1; new_val = 0;
            end
`endif
        end
        m_pend = new_pend;
        m_pend_val = new_val;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: per-cycle bus/stall outputs, and LLbit writes whenever the design raises one.
    always @(negedge clk) begin
        exp_t   e;
        pulse_t p;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("mem_we_o", 32'(mem_we_o), 32'(e.mem_we));
            checkOutput("stallreq_o", 32'(stallreq_o), 32'(e.stall));
            checkOutput("sc_result_o", 32'(sc_result_o), 32'(e.sc_res));
        end
        if (pulse_q.size() > 0 && pulse_q[0].cyc == cyc) begin
            p = pulse_q.pop_front();
            checkOutput("LLbit_we_o", 32'(LLbit_we_o), 32'd1);
            checkOutput("LLbit_o", 32'(LLbit_o), 32'(p.val));
        end else if (LLbit_we_o) begin
            checkOutput("LLbit_we_o_unexpected", 32'(LLbit_we_o), 32'd0);
        end
    end

    initial begin
        stim_t s;
        logic [ADDR_W-1:0] pool [4];
        logic [ADDR_W-1:0] last_addr;
        int op;
        pool[0] = 32'h100; pool[1] = 32'h102; pool[2] = 32'h104; pool[3] = 32'h200;
        last_addr = 32'h100;
        rst = 1; flush = 0; is_ll = 0; is_sc = 0; mem_addr = '0; LLbit_i = 0;
        wb_LLbit_we = 0; wb_LLbit_val = 0; snoop_we = 0; snoop_addr = '0; mem_ack = 0;
        @(posedge clk);
        #1;
        s = idle_s(); s.rst = 1;
        applyStimulus(s); applyStimulus(s);
        s = idle_s();
        applyStimulus(s);

        // LL with a late ack, then SC that relies on the bypassed LLbit write.
        s = idle_s(); s.is_ll = 1; s.addr = 32'h100;
        applyStimulus(s); applyStimulus(s); applyStimulus(s);
        s.ack = 1; applyStimulus(s);
        s = idle_s(); s.is_sc = 1; s.addr = 32'h100; s.wb_we = 1; s.wb_val = 1;
        applyStimulus(s);
        s.wb_we = 0; s.llbit_i = 1; applyStimulus(s);
        s.ack = 1; applyStimulus(s);
        s = idle_s(); applyStimulus(s); applyStimulus(s);

        // SC with a clear LLbit fails without touching the bus.
        s = idle_s(); s.is_sc = 1; s.addr = 32'h100; s.ack = 1;
        applyStimulus(s);
        s = idle_s(); applyStimulus(s);

        // Foreign write to the linked granule, then SC.
        s = idle_s(); s.is_ll = 1; s.addr = 32'h100; applyStimulus(s);
        s.ack = 1; applyStimulus(s);
        s = idle_s(); s.llbit_i = 1; applyStimulus(s);
        s.sn_we = 1; s.sn_addr = 32'h102; applyStimulus(s);
        s = idle_s();
`ifdef LLSC_ADDR_CHECK_EN
        s.llbit_i = 0;
`else
        s.llbit_i = 1;
`endif
        applyStimulus(s);
        s.is_sc = 1; s.addr = 32'h100; applyStimulus(s);
        s.ack = 1; s.is_sc = 0; applyStimulus(s);
        s = idle_s(); applyStimulus(s); applyStimulus(s);

        // SC to the neighbouring word of the link.
        s = idle_s(); s.is_ll = 1; s.addr = 32'h100; applyStimulus(s);
        s.ack = 1; applyStimulus(s);
        s = idle_s(); s.llbit_i = 1; applyStimulus(s);
        s.is_sc = 1; s.addr = 32'h104; applyStimulus(s);
        s.ack = 1; s.is_sc = 0; applyStimulus(s);
        s = idle_s(); applyStimulus(s); applyStimulus(s);

        // Flush while the SC store is outstanding.
        s = idle_s(); s.is_ll = 1; s.addr = 32'h100; applyStimulus(s);
        s.ack = 1; applyStimulus(s);
        s = idle_s(); s.llbit_i = 1; s.is_sc = 1; s.addr = 32'h100; applyStimulus(s);
        s.is_sc = 0; applyStimulus(s);
        s.flush = 1; s.ack = 1; applyStimulus(s);
        s = idle_s(); s.ack = 1; applyStimulus(s); applyStimulus(s);

        for (int i = 0; i < 4000; i++) begin
            s = idle_s();
            s.rst   = ($urandom_range(0, 199) == 0);
            s.flush = ($urandom_range(0, 39) == 0);
            s.addr  = (m_busy_ll || m_busy_sc) ? last_addr : pool[$urandom_range(0, 3)];
            op = int'($urandom_range(0, 3));
            s.is_ll   = (op == 0);
            s.is_sc   = (op == 1);
            s.llbit_i = 1'($urandom_range(0, 1));
            s.wb_we   = ($urandom_range(0, 3) == 0);
            s.wb_val  = 1'($urandom_range(0, 1));
            s.sn_we   = ($urandom_range(0, 3) == 0);
            s.sn_addr = pool[$urandom_range(0, 3)];
            s.ack     = ($urandom_range(0, 2) == 0);
            last_addr = s.addr;
            applyStimulus(s);
        end

        s = idle_s(); s.ack = 1;
        applyStimulus(s); applyStimulus(s); applyStimulus(s);
        checkOutput("pulse_q_drained", 32'(pulse_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
